inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 77 +++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: a byte-addressed PC feeds a combinational instruction memory,
// and one registered output slot hands each instruction to decode with a valid/ready handshake.
module inst_fetch #(
    parameter logic [7:0]  RESET_PC  = 8'h00,
    parameter logic [31:0] HALT_INST = 32'h0000_0073
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [5:0]  imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [7:0]  out_pc,
    output logic        halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pc;
    logic       load;
    logic       halt_hit;

    assign imem_addr = pc[7:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Redirect outranks everything, including a halt word arriving in the same cycle.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = RUN;
        end else if (halt_hit) begin
            state_next = HALT;
        end
    end

    always_comb begin
        halted   = (state == HALT);
        load     = (state == RUN) && (!out_valid || out_ready) && !redirect_valid;
        halt_hit = load && (imem_data == HALT_INST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_pc    <= '0;
        end else if (redirect_valid) begin
            // Targets are word aligned; the flush applies even while decode is stalling.
            pc        <= redirect_pc & 8'hFC;
            out_valid <= 1'b0;
        end else if (load) begin
            out_inst  <= imem_data;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= pc + 8'd4;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
